// File: rtl/dtree_feature_feeder_pkg.sv
// Types and constants shared by the dtree feature feeder and the dtree control logic.
package dtree_feature_feeder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } feed_state_e;

  localparam int SLICE_W = 10;

  // Counter width that stays legal when the count range collapses to a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtree_feature_feeder_vector_fifo.sv
// Small FIFO of whole feature vectors; the head entry is visible combinationally.
module vector_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage is left unreset so it can map onto plain RAM; only occupancy is cleared.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + 1'b1;
      end else if (pop_i && !push_i) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/dtree_feature_feeder.sv
// Buffers feature vectors and replays each one into dtree, one feature per clock,
// pass after pass until dtree reports a result or the pass limit is exhausted.
module dtree_feature_feeder
  import dtree_feature_feeder_pkg::*;
#(
  parameter int FEATURES   = 3,
  parameter int IN_WIDTH   = SLICE_W,
  parameter int DEPTH      = 2,
  parameter int MAX_PASSES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [FEATURES*IN_WIDTH-1:0] in_vec,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [IN_WIDTH-1:0]          sample,
  output logic                         sample_valid,
  output logic                         sample_first,
  input  logic                         tree_done,
  output logic                         busy,
  output logic                         abort
);

  localparam int VW = FEATURES * IN_WIDTH;
  localparam int FW = cnt_w(FEATURES);
  localparam int PW = $clog2(MAX_PASSES + 1);

  feed_state_e       state_q, state_d;
  logic [VW-1:0]     work_q, work_d;
  logic [FW-1:0]     feat_idx_q, feat_idx_d, feat_nxt;
  logic [PW-1:0]     pass_q, pass_d, pass_nxt;
  logic [IN_WIDTH-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              sample_first_q, sample_first_d;
  logic              abort_q, abort_d;

  logic [VW-1:0]     fifo_head;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [IN_WIDTH-1:0] work_feat [FEATURES];

  for (genvar gi = 0; gi < FEATURES; gi++) begin : g_feat
    assign work_feat[gi] = work_q[gi*IN_WIDTH +: IN_WIDTH];
  end

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  vector_fifo #(
    .WIDTH(VW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_ni (reset),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .data_i (in_vec),
    .head_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // feat_idx_q/pass_q describe the sample currently on the output register.
  always_comb begin
    state_d        = state_q;
    work_d         = work_q;
    feat_idx_d     = feat_idx_q;
    pass_d         = pass_q;
    sample_d       = '0;
    sample_valid_d = 1'b0;
    sample_first_d = 1'b0;
    abort_d        = 1'b0;
    fifo_pop       = 1'b0;
    feat_nxt       = (feat_idx_q == FW'(FEATURES - 1)) ? '0 : feat_idx_q + 1'b1;
    pass_nxt       = (feat_idx_q == FW'(FEATURES - 1)) ? pass_q + 1'b1 : pass_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop       = 1'b1;
          work_d         = fifo_head;
          feat_idx_d     = '0;
          pass_d         = '0;
          sample_d       = fifo_head[IN_WIDTH-1:0];
          sample_valid_d = 1'b1;
          sample_first_d = 1'b1;
          state_d        = FEED;
        end
      end
      FEED: begin
        // tree_done is checked first so it wins over a coincident pass-limit wrap.
        if (tree_done) begin
          state_d = IDLE;
        end else if (pass_nxt == PW'(MAX_PASSES)) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          feat_idx_d     = feat_nxt;
          pass_d         = pass_nxt;
          sample_d       = work_feat[feat_nxt];
          sample_valid_d = 1'b1;
          sample_first_d = (feat_nxt == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      work_q         <= '0;
      feat_idx_q     <= '0;
      pass_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      sample_first_q <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      work_q         <= work_d;
      feat_idx_q     <= feat_idx_d;
      pass_q         <= pass_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      sample_first_q <= sample_first_d;
      abort_q        <= abort_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign sample_first = sample_first_q;
  assign abort        = abort_q;
  assign busy         = (state_q == FEED);

endmodule

// File: tb/tb_dtree_feature_feeder.sv
// Directed bench for dtree_feature_feeder: inputs change and outputs are checked on the falling edge.
module tb_dtree_feature_feeder;

  logic        clk;
  logic        reset;
  logic [29:0] in_vec;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  sample;
  logic        sample_valid;
  logic        sample_first;
  logic        tree_done;
  logic        busy;
  logic        abort;

  int n_vec = 0;
  int n_err = 0;

  // Feature 2 is the leftmost field of each vector.
  logic [29:0] v1 = {10'd3,   10'h3FE, 10'd5};
  logic [29:0] va = {10'd12,  10'd11,  10'd10};
  logic [29:0] vb = {10'h200, 10'h1FF, 10'd0};
  logic [29:0] vc = {10'd33,  10'd22,  10'd11};
  logic [29:0] vd = {10'd7,   10'd6,   10'h3F0};
  logic [29:0] ve = {10'd102, 10'd101, 10'd100};
  logic [29:0] vf = {10'd202, 10'd201, 10'd200};
  logic [29:0] vg = {10'd302, 10'd301, 10'd300};

  dtree_feature_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .in_vec      (in_vec),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_first(sample_first),
    .tree_done   (tree_done),
    .busy        (busy),
    .abort       (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_live(input string tag, input logic [9:0] val, input logic first);
    check({tag, ".valid"},  32'(sample_valid), 32'd1);
    check({tag, ".sample"}, 32'(sample),       32'(val));
    check({tag, ".first"},  32'(sample_first), 32'(first));
    check({tag, ".busy"},   32'(busy),         32'd1);
    check({tag, ".abort"},  32'(abort),        32'd0);
  endtask

  task automatic expect_quiet(input string tag, input logic exp_abort);
    check({tag, ".valid"}, 32'(sample_valid), 32'd0);
    check({tag, ".busy"},  32'(busy),         32'd0);
    check({tag, ".abort"}, 32'(abort),        32'(exp_abort));
  endtask

  // Checks n consecutive samples of v starting at stream position k0 (position k is feature k%3).
  task automatic expect_stream(input string tag, input logic [29:0] v, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      if (k > k0) @(negedge clk);
      expect_live($sformatf("%s[%0d]", tag, k), v[(k % 3) * 10 +: 10], ((k % 3) == 0));
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_vec    = '0;
    in_valid  = 1'b0;
    tree_done = 1'b0;

    // 1: reset state, then idle with stray tree_done pulses
    repeat (2) @(negedge clk);
    expect_quiet("t1.rst", 1'b0);
    check("t1.rst.sample", 32'(sample), 32'd0);
    check("t1.rst.first", 32'(sample_first), 32'd0);
    check("t1.rst.in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      expect_quiet($sformatf("t1.idle%0d", i), 1'b0);
      check($sformatf("t1.idle%0d.in_ready", i), 32'(in_ready), 32'd1);
      tree_done = (i % 2 == 1);
    end
    tree_done = 1'b0;

    // 2: single vector, tree_done on the 2nd-pass f2
    @(negedge clk);
    in_vec   = v1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    expect_quiet("t2.load", 1'b0);
    @(negedge clk);
    expect_stream("t2", v1, 0, 6);
    tree_done = 1'b1;
    @(negedge clk);
    tree_done = 1'b0;
    expect_quiet("t2.retire", 1'b0);
    @(negedge clk);
    expect_quiet("t2.after", 1'b0);

    // 3: three vectors back-to-back, buffer fills, one bubble between vectors
    @(negedge clk);
    check("t3.n0.in_ready", 32'(in_ready), 32'd1);
    in_vec   = va;
    in_valid = 1'b1;
    @(negedge clk);
    expect_quiet("t3.n1", 1'b0);
    check("t3.n1.in_ready", 32'(in_ready), 32'd1);
    in_vec = vb;
    @(negedge clk);
    expect_live("t3.A0", 10'd10, 1'b1);
    check("t3.n2.in_ready", 32'(in_ready), 32'd1);
    in_vec = vc;
    @(negedge clk);
    expect_live("t3.A1", 10'd11, 1'b0);
    check("t3.n3.in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    expect_live("t3.A2", 10'd12, 1'b0);
    check("t3.n4.in_ready", 32'(in_ready), 32'd0);
    tree_done = 1'b1;
    @(negedge clk);
    tree_done = 1'b0;
    expect_quiet("t3.bubbleAB", 1'b0);
    check("t3.n5.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    expect_stream("t3.B", vb, 0, 4);
    tree_done = 1'b1;
    @(negedge clk);
    tree_done = 1'b0;
    expect_quiet("t3.bubbleBC", 1'b0);
    check("t3.bubbleBC.in_ready", 32'(in_ready), 32'd1);
    in_vec   = vd;
    in_valid = 1'b1;

    // 4: no tree_done -> 12 samples, one-cycle abort, buffered vector follows
    @(negedge clk);
    in_valid = 1'b0;
    check("t4.in_ready", 32'(in_ready), 32'd1);
    expect_stream("t4.C", vc, 0, 12);
    @(negedge clk);
    expect_quiet("t4.abort", 1'b1);

    // 5: tree_done on the 12th sample (4th-pass wrap) -> retire without abort
    @(negedge clk);
    expect_stream("t5.D", vd, 0, 12);
    tree_done = 1'b1;
    @(negedge clk);
    tree_done = 1'b0;
    expect_quiet("t5.retire", 1'b0);
    @(negedge clk);
    expect_quiet("t5.after", 1'b0);

    // 6: asynchronous reset in pass 1 with two vectors still buffered
    @(negedge clk);
    in_vec   = ve;
    in_valid = 1'b1;
    @(negedge clk);
    expect_quiet("t6.load", 1'b0);
    in_vec = vf;
    @(negedge clk);
    expect_live("t6.E0", 10'd100, 1'b1);
    check("t6.n2.in_ready", 32'(in_ready), 32'd1);
    in_vec = vg;
    @(negedge clk);
    in_valid = 1'b0;
    check("t6.full.in_ready", 32'(in_ready), 32'd0);
    expect_stream("t6.E", ve, 1, 4);
    #2;
    reset = 1'b0;
    #1;
    expect_quiet("t6.async", 1'b0);
    check("t6.async.sample", 32'(sample), 32'd0);
    check("t6.async.first", 32'(sample_first), 32'd0);
    check("t6.async.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      expect_quiet($sformatf("t6.post%0d", i), 1'b0);
      check($sformatf("t6.post%0d.in_ready", i), 32'(in_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
